// File: rtl/reg_dump.sv
// Streams a contiguous (wrapping) range of register-file words out over a
// valid/ready interface. Define REG_DUMP_PARITY_EN to add the outParity output.
module reg_dump #(
  parameter int WORD_LENGTH = 8,
  parameter int REG_AMOUNT  = 8,
  localparam int AW = $clog2(REG_AMOUNT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [AW-1:0]          firstAddr,
  input  logic [AW-1:0]          lastAddr,
  output logic [AW-1:0]          rfAddr,
  input  logic [WORD_LENGTH-1:0] rfData,
  output logic                   outValid,
  input  logic                   outReady,
  output logic [WORD_LENGTH-1:0] outData,
  output logic [AW-1:0]          outAddr,
  output logic                   outLast,
  output logic                   busy,
  output logic                   done
`ifdef REG_DUMP_PARITY_EN
  ,
  output logic                   outParity
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    DONE
  } state_t;

  localparam logic [AW-1:0] LAST_REG = AW'(REG_AMOUNT - 1);

  state_t        state;
  state_t        state_next;
  logic [AW-1:0] pointer;
  logic [AW-1:0] end_addr;
  logic [AW-1:0] next_addr;
  logic          accept;
  logic          capture;
  logic          handshake;

  assign rfAddr = pointer;

  // Explicit wrap so non-power-of-two register files also dump across the end.
  assign next_addr = (pointer == LAST_REG) ? '0 : pointer + AW'(1);

  assign accept    = (state == IDLE) && start && !abort;
  assign capture   = (state == LOAD) && !abort;
  assign handshake = (state == SEND) && !abort && outValid && outReady;

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept) state_next = LOAD;
      LOAD: state_next = abort ? IDLE : SEND;
      SEND: begin
        if (abort)          state_next = IDLE;
        else if (handshake) state_next = outLast ? DONE : LOAD;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pointer  <= '0;
      end_addr <= '0;
      outValid <= 1'b0;
      outData  <= '0;
      outAddr  <= '0;
      outLast  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      done <= (state_next == DONE);

      if (accept) begin
        pointer  <= firstAddr;
        end_addr <= lastAddr;
      end

      if (capture) begin
        outData  <= rfData;
        outAddr  <= pointer;
        outLast  <= (pointer == end_addr);
        outValid <= 1'b1;
      end else if (handshake || abort) begin
        outValid <= 1'b0;
      end

      // The pointer stays on the final address once the last word leaves.
      if (handshake && !outLast) pointer <= next_addr;
    end
  end

`ifdef REG_DUMP_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n)       outParity <= 1'b0;
    else if (capture) outParity <= ^rfData;
  end
`endif

endmodule

// File: tb/tb_reg_dump.sv
// Self-checking bench for reg_dump: directed dumps plus randomized ranges and
// backpressure, checked against an address/data list built from the range rule.
module tb_reg_dump;

  localparam int WL = 8;
  localparam int N  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [AW-1:0] firstAddr;
  logic [AW-1:0] lastAddr;
  logic [AW-1:0] rfAddr;
  logic [WL-1:0] rfData;
  logic          outValid;
  logic          outReady;
  logic [WL-1:0] outData;
  logic [AW-1:0] outAddr;
  logic          outLast;
  logic          busy;
  logic          done;
`ifdef REG_DUMP_PARITY_EN
  logic          outParity;
`endif

  logic [WL-1:0] regs [N];
  assign rfData = regs[rfAddr];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_dump #(.WORD_LENGTH(WL), .REG_AMOUNT(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .firstAddr (firstAddr),
    .lastAddr  (lastAddr),
    .rfAddr    (rfAddr),
    .rfData    (rfData),
    .outValid  (outValid),
    .outReady  (outReady),
    .outData   (outData),
    .outAddr   (outAddr),
    .outLast   (outLast),
    .busy      (busy),
    .done      (done)
`ifdef REG_DUMP_PARITY_EN
    ,
    .outParity (outParity)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_valid"}, outValid, 0);
    check({tag, "_busy"},  busy,     0);
    check({tag, "_done"},  done,     0);
  endtask

  // mode 0: always ready; 1: random ready; 2: ready held low 5 cycles per word.
  // abort_at: index of the word whose SEND phase is aborted, -1 for none.
  task automatic run_dump(input int first, input int last, input int mode, input int abort_at);
    logic [AW-1:0] exp_addr [$];
    logic [WL-1:0] exp_data [$];
    int            count;
    int            idx;
    int            dones;
    int            cycles;
    int            stall;
    bit            aborted;
    bit            v;
    bit            hs;
    logic [WL-1:0] snap_data;
    logic [AW-1:0] snap_addr;
    logic          snap_last;

    count = ((last - first + N) % N) + 1;
    for (int k = 0; k < count; k++) begin
      exp_addr.push_back(AW'((first + k) % N));
      exp_data.push_back(regs[(first + k) % N]);
    end

    firstAddr = AW'(first);
    lastAddr  = AW'(last);
    start     = 1'b1;
    tick();
    start     = 1'b0;
    firstAddr = AW'($urandom);
    lastAddr  = AW'($urandom);
    check("load_busy",  busy,     1);
    check("load_valid", outValid, 0);

    idx = 0; dones = 0; cycles = 0; stall = 0; aborted = 1'b0;
    while (busy && cycles < 400) begin
      case (mode)
        0:       outReady = 1'b1;
        1:       outReady = 1'($urandom_range(0, 1));
        default: outReady = (stall >= 5);
      endcase
      start     = 1'($urandom_range(0, 1));
      firstAddr = AW'($urandom);
      lastAddr  = AW'($urandom);
      if (outValid && idx == abort_at) begin
        abort    = 1'b1;
        outReady = 1'b1;
      end
      v  = outValid;
      hs = outValid && outReady && !abort;
      snap_data = outData;
      snap_addr = outAddr;
      snap_last = outLast;

      if (hs) begin
        if (idx < count) begin
          check("word_addr", outAddr, exp_addr[idx]);
          check("word_data", outData, exp_data[idx]);
          check("word_last", outLast, (idx == count - 1));
`ifdef REG_DUMP_PARITY_EN
          check("word_parity", outParity, ^exp_data[idx]);
`endif
        end else begin
          check("extra_word", 1, 0);
        end
        idx++;
        stall = 0;
      end else if (v) begin
        stall++;
      end

      tick();
      cycles++;

      if (abort) begin
        abort   = 1'b0;
        start   = 1'b0;
        aborted = 1'b1;
        check_quiet("abort");
        break;
      end
      if (v && !hs) begin
        check("hold_valid", outValid, 1);
        check("hold_data",  outData,  snap_data);
        check("hold_addr",  outAddr,  snap_addr);
        check("hold_last",  outLast,  snap_last);
      end
      if (done) dones++;
    end
    start = 1'b0;

    check("dump_finished", busy, 0);
    if (aborted) begin
      check("abort_words", idx, abort_at);
      for (int k = 0; k < 3; k++) begin
        tick();
        check_quiet("after_abort");
      end
    end else begin
      check("word_count", idx, count);
      check("done_pulses", dones, 1);
      if (mode == 0) check("throughput_cycles", cycles, 2 * count + 1);
      check("idle_done", done, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; outReady = 1'b0;
    firstAddr = '0; lastAddr = '0;
    for (int i = 0; i < N; i++) regs[i] = WL'(8'h10 + i);

    // Start is asserted during reset: reset must still win.
    start = 1'b1;
    tick(); tick();
    start = 1'b0;
    check("rst_valid", outValid, 0);
    check("rst_data",  outData,  0);
    check("rst_addr",  outAddr,  0);
    check("rst_last",  outLast,  0);
    check("rst_busy",  busy,     0);
    check("rst_done",  done,     0);
    check("rst_rfaddr", rfAddr,  0);
    rst_n = 1'b1;
    tick();

    run_dump(2, 5, 0, -1);
    run_dump(6, 1, 0, -1);
    run_dump(3, 3, 0, -1);
    run_dump(2, 5, 2, -1);
    run_dump(2, 5, 0, 2);
    run_dump(0, 7, 1, -1);

    // start together with abort in IDLE is not a request.
    firstAddr = 3'd1; lastAddr = 3'd4; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check_quiet("start_with_abort");

    repeat (12) begin
      for (int i = 0; i < N; i++) regs[i] = WL'($urandom);
      run_dump($urandom_range(0, N - 1), $urandom_range(0, N - 1), 1, -1);
    end
    run_dump(7, 6, 1, -1);
    run_dump(5, 2, 2, 1);

    // Reset in the middle of a dump.
    firstAddr = 3'd1; lastAddr = 3'd6; start = 1'b1; outReady = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_valid",  outValid, 0);
    check("mid_rst_data",   outData,  0);
    check("mid_rst_addr",   outAddr,  0);
    check("mid_rst_last",   outLast,  0);
    check("mid_rst_busy",   busy,     0);
    check("mid_rst_done",   done,     0);
    check("mid_rst_rfaddr", rfAddr,   0);
`ifdef REG_DUMP_PARITY_EN
    check("mid_rst_parity", outParity, 0);
`endif
    for (int k = 0; k < 4; k++) begin
      tick();
      check_quiet("after_reset");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_dump.md
REG_DUMP -- requirements
Module: reg_dump

Interface
REQ-001 Parameter WORD_LENGTH, default 8, width of a register word.
REQ-002 Parameter REG_AMOUNT, default 8, number of registers in the attached register file; AW = $clog2(REG_AMOUNT).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request a dump; sampled only in IDLE.
REQ-006 abort  input  1  terminate a dump in progress.
REQ-007 firstAddr  input  AW  first register to dump; sampled with start.
REQ-008 lastAddr  input  AW  last register to dump; sampled with start.
REQ-009 rfAddr  output  AW  read address driven to the register file read port.
REQ-010 rfData  input  WORD_LENGTH  combinational read data returned for rfAddr.
REQ-011 outValid  output  1  stream word valid.
REQ-012 outReady  input  1  downstream accepts the word.
REQ-013 outData  output  WORD_LENGTH  dumped register value.
REQ-014 outAddr  output  AW  address outData was read from.
REQ-015 outLast  output  1  outData is the final word of the dump.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse on normal completion.

Function
REQ-018 FSM states IDLE, LOAD, SEND, DONE; all outputs registered except rfAddr, which SHALL equal the internal pointer register.
REQ-019 IDLE: start=1 and abort=0 at an edge -> pointer<=firstAddr, end<=lastAddr, next state LOAD.
REQ-020 LOAD (exactly one cycle): capture outData<=rfData, outAddr<=pointer, outLast<=(pointer==end), outValid<=1; next state SEND.
REQ-021 SEND: outValid, outData, outAddr and outLast SHALL be held stable until outValid&&outReady at an edge.
REQ-022 SEND handshake with outLast=0 -> outValid<=0, pointer<=next address, next state LOAD; with outLast=1 -> outValid<=0, next state DONE.
REQ-023 Next address = pointer+1, wrapping from REG_AMOUNT-1 to 0, so lastAddr<firstAddr dumps across the wrap.
REQ-024 firstAddr==lastAddr SHALL produce exactly one word, with outLast=1.
REQ-025 Word count SHALL be ((lastAddr-firstAddr) mod REG_AMOUNT)+1; maximum throughput is one word per 2 cycles.
REQ-026 DONE: done=1 for exactly one cycle, then IDLE; start is not accepted in DONE.
REQ-027 start while busy=1 SHALL be ignored; firstAddr and lastAddr changes after sampling SHALL have no effect.
REQ-028 abort=1 at an edge in LOAD, SEND or DONE -> IDLE, outValid<=0, done<=0; no further words; abort wins over start and over a simultaneous handshake.
REQ-029 Register file writes during a dump are permitted; each word SHALL be the rfData value present at its LOAD edge.
REQ-030 In IDLE the pointer SHALL hold its last value; outData, outAddr and outLast hold their last values, valid only with outValid.

Reset
REQ-031 rst_n=0 at an edge -> IDLE, pointer=0, outValid=0, outData=0, outAddr=0, outLast=0, busy=0, done=0.
REQ-032 Reset mid-dump SHALL discard the dump with no done pulse; rst_n has priority over all other inputs.

Configuration
REQ-033 Macro REG_DUMP_PARITY_EN defined: add output outParity (1 bit) = XOR of the captured word, giving even parity over outData and outParity, registered in LOAD with outData, reset to 0, held with outData.
REQ-034 Macro REG_DUMP_PARITY_EN undefined: outParity port and logic absent; all other behaviour identical.

Verification
REQ-035 Regfile preloaded with reg[i]=8'h10+i; first=2, last=5, outReady=1 -> words 12,13,14,15 at addr 2..5, outLast only on 15, one done pulse.
REQ-036 first=6, last=1 -> addresses 6,7,0,1 with data 16,17,10,11 (wrap); first=last=3 -> single word 13, outLast=1.
REQ-037 outReady low for 5 cycles during SEND -> outData, outAddr and outLast stable throughout; no word lost or duplicated.
REQ-038 abort asserted while the third of four words is in SEND -> IDLE next cycle, outValid=0, no done pulse; start pulsed during a dump is ignored.
REQ-039 Reset mid-dump -> all outputs 0 next cycle; with REG_DUMP_PARITY_EN, word 8'h13 gives outParity=1 and word 8'h12 gives outParity=0.
